st7735_cmd_ctrl: RTL and testbench

//  Sequencer behind the SPI slave. Decodes its byte stream ({data, dc, rxdone}) as ST7735R

---
 rtl/st7735_cmd_ctrl_pkg.sv | 23 ++
 rtl/st7735_win_cursor.sv | 72 +++++++
 rtl/st7735_cmd_ctrl.sv | 111 +++++++++++
 tb/tb_st7735_cmd_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/st7735_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : st7735_cmd_ctrl_pkg
//  Brief    : ST7735R opcodes and command-sequencer state encoding
//  Revision : 1.0  initial release
// ============================================================================
package st7735_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COL    = 3'd1,
    ROW    = 3'd2,
    PIX_HI = 3'd3,
    PIX_LO = 3'd4,
    SKIP   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/st7735_win_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : st7735_win_cursor
//  Brief    : Address window registers plus x/y cursor with wrap and clipping
//  Revision : 1.0  initial release
// ============================================================================
module st7735_win_cursor #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_commit_col,
  input  logic              i_commit_row,
  input  logic [31:0]       i_win,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_range
);

  localparam logic [15:0]       c_h_res  = 16'(H_RES);
  localparam logic [15:0]       c_v_res  = 16'(V_RES);
  localparam logic [ADDR_W-1:0] c_h_step = ADDR_W'(H_RES);

  logic [15:0]       r_xs, r_xe, r_ys, r_ye;
  logic [15:0]       r_x, r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] w_ys_base;

  // Modular product: only the low ADDR_W bits ever matter for an unclipped row.
  assign w_ys_base = ADDR_W'(r_ys) * c_h_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xs       <= '0;
      r_xe       <= c_h_res - 16'd1;
      r_ys       <= '0;
      r_ye       <= c_v_res - 16'd1;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else begin
      if (i_commit_col) {r_xs, r_xe} <= i_win;
      if (i_commit_row) {r_ys, r_ye} <= i_win;
      if (i_load) begin
        r_x        <= r_xs;
        r_y        <= r_ys;
        r_row_base <= w_ys_base;
      end else if (i_step) begin
        if (r_x >= r_xe) begin
          r_x <= r_xs;
          if (r_y >= r_ye) begin
            r_y        <= r_ys;
            r_row_base <= w_ys_base;
          end else begin
            r_y        <= r_y + 16'd1;
            r_row_base <= r_row_base + c_h_step;
          end
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  assign o_in_range = (r_x < c_h_res) && (r_y < c_v_res);
  assign o_addr     = r_row_base + ADDR_W'(r_x);

endmodule
`default_nettype wire

// File: rtl/st7735_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : st7735_cmd_ctrl
//  Brief    : ST7735R CASET/RASET/RAMWR decoder driving a frame-buffer write port
//  Revision : 1.0  initial release
// ============================================================================
module st7735_cmd_ctrl
  import st7735_cmd_ctrl_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_dc,
  input  logic              i_rxdone,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_frame_start
);

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [23:0]       r_shadow;
  logic [7:0]        r_hi;

  logic              w_cmd, w_dat;
  logic              w_load, w_step, w_commit_col, w_commit_row;
  logic [31:0]       w_win;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;

  assign w_cmd        = i_rxdone & ~i_dc;
  assign w_dat        = i_rxdone & i_dc;
  assign w_load       = w_cmd && (i_data == CMD_RAMWR);
  assign w_step       = w_dat && (r_state == PIX_LO);
  assign w_commit_col = w_dat && (r_state == COL) && (r_idx == 2'd3);
  assign w_commit_row = w_dat && (r_state == ROW) && (r_idx == 2'd3);
  assign w_win        = {r_shadow, i_data};

  st7735_win_cursor #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_commit_col (w_commit_col),
    .i_commit_row (w_commit_row),
    .i_win        (w_win),
    .o_addr       (w_addr),
    .o_in_range   (w_in_range)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_hi          <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_wr_en       <= 1'b0;
      o_frame_start <= 1'b0;
      // A command byte always wins, discarding any partial window or pixel.
      if (w_cmd) begin
        r_idx <= '0;
        case (i_data)
          CMD_CASET: r_state <= COL;
          CMD_RASET: r_state <= ROW;
          CMD_RAMWR: begin
            r_state       <= PIX_HI;
            o_frame_start <= 1'b1;
          end
          default:   r_state <= SKIP;
        endcase
      end else if (w_dat) begin
        case (r_state)
          COL, ROW: begin
            r_shadow <= {r_shadow[15:0], i_data};
            r_idx    <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= SKIP;
          end
          PIX_HI: begin
            r_hi    <= i_data;
            r_state <= PIX_LO;
          end
          PIX_LO: begin
            r_state <= PIX_HI;
            if (w_in_range) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= w_addr;
              o_wr_data <= {r_hi, i_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_st7735_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_st7735_cmd_ctrl
//  Brief    : Directed self-checking bench for st7735_cmd_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_st7735_cmd_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_data;
  logic        i_dc;
  logic        i_rxdone;
  logic        o_wr_en;
  logic [14:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_frame_start;

  int vectors    = 0;
  int miscompares = 0;
  int fs_cnt     = 0;
  int overlap    = 0;
  logic [31:0] wq[$];

  always #5 i_clk = ~i_clk;

  st7735_cmd_ctrl #(.H_RES(160), .V_RES(128), .ADDR_W(15)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data        (i_data),
    .i_dc          (i_dc),
    .i_rxdone      (i_rxdone),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_frame_start (o_frame_start)
  );

  // Observe write/frame strobes on the falling edge, clear of the active edge.
  always @(negedge i_clk) begin
    if (o_wr_en) wq.push_back({1'b0, o_wr_addr, o_wr_data});
    if (o_frame_start) fs_cnt++;
    if (o_wr_en && o_frame_start) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int a, input logic [15:0] d);
    return {a[15:0], d};
  endfunction

  function automatic logic [31:0] got(input int i);
    return (wq.size() > i) ? wq[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic send(input logic dc, input logic [7:0] b);
    @(negedge i_clk);
    i_dc = dc; i_data = b; i_rxdone = 1'b1;
    @(negedge i_clk);
    i_rxdone = 1'b0;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic pixel(input logic [15:0] p);
    send(1'b1, p[15:8]);
    send(1'b1, p[7:0]);
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    wq.delete();
    fs_cnt = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_data = '0; i_dc = 1'b0; i_rxdone = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
    check("rst_wr_addr", {17'd0, o_wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, o_wr_data}, 32'd0);
    check("rst_frame_start", {31'd0, o_frame_start}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 1: first RAMWR with default window
    wq.delete(); fs_cnt = 0;
    send(1'b0, 8'h2C);
    check("t1_frame_start", fs_cnt, 32'd1);
    pixel(16'hF800);
    check("t1_count", wq.size(), 32'd1);
    check("t1_w0", got(0), ent(0, 16'hF800));

    // 2: 2x2 window with wrap back to the start
    do_reset();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h02); send(1'b1, 8'h00); send(1'b1, 8'h03);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h01); send(1'b1, 8'h00); send(1'b1, 8'h02);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'hA500 + 16'(i));
    check("t2_count", wq.size(), 32'd5);
    check("t2_w0", got(0), ent(162, 16'hA500));
    check("t2_w1", got(1), ent(163, 16'hA501));
    check("t2_w2", got(2), ent(322, 16'hA502));
    check("t2_w3", got(3), ent(323, 16'hA503));
    check("t2_w4", got(4), ent(162, 16'hA504));

    // 3: right-edge window, second pixel clipped at x=160
    do_reset();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h9F); send(1'b1, 8'h00); send(1'b1, 8'hA0);
    send(1'b0, 8'h2C);
    pixel(16'h07E0);
    pixel(16'h001F);
    check("t3_count", wq.size(), 32'd1);
    check("t3_w0", got(0), ent(159, 16'h07E0));

    // 4: aborted CASET leaves the window untouched
    do_reset();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05);
    send(1'b0, 8'h2C);
    pixel(16'hBEEF);
    check("t4_count", wq.size(), 32'd1);
    check("t4_w0", got(0), ent(0, 16'hBEEF));

    // 5: unknown opcode skipped, dangling high byte dropped
    do_reset();
    send(1'b0, 8'h36); send(1'b1, 8'h60);
    check("t5_skip_nowrite", wq.size(), 32'd0);
    send(1'b0, 8'h2C); send(1'b1, 8'hAB);
    send(1'b0, 8'h2C);
    pixel(16'h1234);
    check("t5_count", wq.size(), 32'd1);
    check("t5_w0", got(0), ent(0, 16'h1234));
    check("t5_frames", fs_cnt, 32'd2);

    // 6: asynchronous reset between high and low byte
    do_reset();
    send(1'b0, 8'h2C);
    pixel(16'hAABB);
    pixel(16'hCCDD);
    check("t6_pre_count", wq.size(), 32'd2);
    check("t6_pre_w1", got(1), ent(1, 16'hCCDD));
    send(1'b1, 8'hEE);
    #3 i_rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", {31'd0, o_wr_en}, 32'd0);
    check("t6_rst_wr_addr", {17'd0, o_wr_addr}, 32'd0);
    check("t6_rst_wr_data", {16'd0, o_wr_data}, 32'd0);
    check("t6_rst_frame_start", {31'd0, o_frame_start}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    wq.delete();
    send(1'b1, 8'h55); send(1'b1, 8'h66); send(1'b1, 8'h77); send(1'b1, 8'h88);
    check("t6_post_nowrite", wq.size(), 32'd0);
    send(1'b0, 8'h2C);
    pixel(16'h4321);
    check("t6_post_ramwr", got(0), ent(0, 16'h4321));

    check("no_overlap", overlap, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
